slow_sig_capture: RTL

//  Parametrised on-chip logic-analyser for slow board signals (cam GPIO, IIC SCL/SDA, sync strobes).

---
 rtl/slow_cap_pkg.sv | 22 ++
 rtl/slow_cap_fifo.sv | 54 +++++
 rtl/slow_sig_capture.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/slow_cap_pkg.sv
// Shared types and helpers for the slow-signal capture block.
package slow_cap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_t;

  localparam int unsigned TS_W_LIMIT = 32;

  function automatic int unsigned entry_w(input int unsigned ts_w, input int unsigned nch);
    return ts_w + nch;
  endfunction

  // All-ones timestamp of the given width; callers truncate to their TS_W.
  function automatic logic [TS_W_LIMIT-1:0] ts_max(input int unsigned ts_w);
    return {TS_W_LIMIT{1'b1}} >> (TS_W_LIMIT - ts_w);
  endfunction

endpackage

// File: rtl/slow_cap_fifo.sv
// Synchronous first-word-fall-through FIFO with flush and fill count.
module slow_cap_fifo
  import slow_cap_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign rd_valid = (count != '0);
  assign do_rd    = rd_valid && rd_ready;
  assign do_wr    = wr_en && (count != (AW+1)'(DEPTH));
  // Gate the read port so nothing stale is presented while empty.
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;
  assign fill     = count;

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      if (do_wr && !do_rd)
        count <= count + (AW+1)'(1);
      else if (!do_wr && do_rd)
        count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/slow_sig_capture.sv
// Triggered change logger for slow probes: sync, optional glitch filter, edge detect, timestamped FIFO.
// Optional glitch filter enabled by defining SLOW_CAP_FILTER_EN.
module slow_sig_capture
  import slow_cap_pkg::*;
#(
  parameter int unsigned NCH      = 9,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned TS_W     = 23,
  parameter int unsigned FILT_LEN = 3
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NCH-1:0]            probe_in,
  input  logic                      arm,
  input  logic                      stop,
  input  logic [NCH-1:0]            trig_mask,
  input  logic [NCH-1:0]            trig_val,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [TS_W+NCH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0]    fill,
  output logic [1:0]                state,
  output logic                      overflow
);

  localparam int unsigned ENTRY_W = entry_w(TS_W, NCH);
  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [TS_W-1:0] TS_MAX = TS_W'(ts_max(TS_W));

`ifdef SLOW_CAP_FILTER_EN
  localparam int unsigned FILT_EN = 1;
`else
  localparam int unsigned FILT_EN = 0;
`endif
  localparam int unsigned FLEN = FILT_EN * FILT_LEN;

  logic [NCH-1:0] sync1;
  logic [NCH-1:0] sync2;
  logic [NCH-1:0] smp;
  logic [NCH-1:0] det_smp;
  logic           det_evt;

  cap_state_t     state_q, state_d;
  logic [TS_W-1:0] ts_q, ts_d, wr_ts;
  logic           ovf_q, ovf_d;
  logic           flush, wr_req, wr_en, full, trig_hit;
  logic [ENTRY_W-1:0] wr_data;

  generate
    if (FLEN >= 1) begin : g_filt
      localparam int unsigned CW = $clog2(FLEN + 1);
      logic [CW-1:0] cnt [NCH];
      always_ff @(posedge clk) begin
        if (!rstn) begin
          smp <= '0;
          for (int unsigned i = 0; i < NCH; i++) cnt[i] <= '0;
        end else begin
          for (int unsigned i = 0; i < NCH; i++) begin
            if (sync2[i] == smp[i])
              cnt[i] <= '0;
            else if (cnt[i] == CW'(FLEN - 1)) begin
              cnt[i] <= '0;
              smp[i] <= sync2[i];
            end else
              cnt[i] <= cnt[i] + CW'(1);
          end
        end
      end
    end else begin : g_nofilt
      assign smp = sync2;
    end
  endgenerate

  // det_smp doubles as the one-cycle-delayed sample, so the edge compare and
  // the logged sample come from the same detect stage.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1   <= '0;
      sync2   <= '0;
      det_smp <= '0;
      det_evt <= 1'b0;
    end else begin
      sync1   <= probe_in;
      sync2   <= sync1;
      det_smp <= smp;
      det_evt <= (smp != det_smp);
    end
  end

  assign trig_hit = (((det_smp ^ trig_val) & trig_mask) == '0);
  assign full     = (fill == (AW+1)'(DEPTH));
  assign wr_data  = {wr_ts, det_smp};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      ts_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ts_d    = ts_q;
    ovf_d   = ovf_q;
    flush   = 1'b0;
    wr_req  = 1'b0;
    wr_en   = 1'b0;
    wr_ts   = ts_q;
    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d = ST_ARMED;
          flush   = 1'b1;
          ovf_d   = 1'b0;
          ts_d    = '0;
        end
      end
      ST_ARMED: begin
        if (stop)
          state_d = ST_DONE;
        else if (trig_hit) begin
          state_d = ST_CAPTURE;
          wr_req  = 1'b1;
          wr_ts   = '0;
          ts_d    = TS_W'(1);
        end
      end
      ST_CAPTURE: begin
        ts_d   = ts_q + TS_W'(1);
        wr_req = det_evt || (ts_q == TS_MAX);
        if (stop) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (fill == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Full is judged on pre-read fill; a dropped write ends the capture.
    if (wr_req) begin
      if (full) begin
        ovf_d   = 1'b1;
        state_d = ST_DONE;
      end else
        wr_en = 1'b1;
    end
  end

  slow_cap_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .flush    (flush),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .fill     (fill)
  );

  assign state    = state_q;
  assign overflow = ovf_q;

endmodule
